// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full_adder cell stepped over WIDTH cycles, LSB first,
// with operand shift registers, carry flop, bit counter and a start/busy/done handshake.
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_done;
  logic             r_busy;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, latch flags on the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= (r_state == S_RUN) && w_last;
      r_busy <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= op_a;
            r_b_sh  <= sub ? ~op_b : op_b;
            r_carry <= sub | cin_in;
            r_cnt   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= r_carry ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): arithmetic, latency, busy-start rejection,
// asynchronous reset mid-operation and back-to-back operation.
`timescale 1ns/1ps

module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin_in   (cin_in),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; operands are scrambled after accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic ci, output logic [W-1:0] sum_acc, output int lat,
                        output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf,
                        output logic busy_at_done, output logic done_after);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; sub = s; cin_in = ci;
    @(posedge clk); #1;
    sum_acc = sum;
    start = 1'b0; op_a = ~a; op_b = ~b; sub = ~s; cin_in = ~ci;
    lat = 0;
    while (lat < 40 && done !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    r_sum = sum; r_cout = cout; r_ovf = overflow; busy_at_done = busy;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin_in = 1'b0; op_a = '0; op_b = '0;
    #22;
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (sum !== 8'h00)     begin n_err++; $display("FAIL reset_sum got=%h exp=00", sum); end
    n_cmp++; if (cout !== 1'b0)     begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [W-1:0] sa, rs; int lat; logic rc, ro, bd, da;
    run_op(8'h3C, 8'h5A, 1'b0, 1'b0, sa, lat, rs, rc, ro, bd, da);
    n_cmp++; if (lat != 8)      begin n_err++; $display("FAIL add1_latency got=%0d exp=8", lat); end
    n_cmp++; if (rs !== 8'h96)  begin n_err++; $display("FAIL add1_sum got=%h exp=96", rs); end
    n_cmp++; if (rc !== 1'b0)   begin n_err++; $display("FAIL add1_cout got=%b exp=0", rc); end
    n_cmp++; if (ro !== 1'b1)   begin n_err++; $display("FAIL add1_ovf got=%b exp=1", ro); end
    n_cmp++; if (bd !== 1'b1)   begin n_err++; $display("FAIL add1_busy_at_done got=%b exp=1", bd); end
    n_cmp++; if (da !== 1'b0)   begin n_err++; $display("FAIL add1_done_width got=%b exp=0", da); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL add1_busy_drop got=%b exp=0", busy); end
    n_cmp++; if (sum !== 8'h96) begin n_err++; $display("FAIL add1_sum_hold got=%h exp=96", sum); end

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, sa, lat, rs, rc, ro, bd, da);
    n_cmp++; if (sa !== 8'h00)  begin n_err++; $display("FAIL add2_sum_clear got=%h exp=00", sa); end
    n_cmp++; if (rs !== 8'h00)  begin n_err++; $display("FAIL add2_sum got=%h exp=00", rs); end
    n_cmp++; if (rc !== 1'b1)   begin n_err++; $display("FAIL add2_cout got=%b exp=1", rc); end
    n_cmp++; if (ro !== 1'b0)   begin n_err++; $display("FAIL add2_ovf got=%b exp=0", ro); end

    run_op(8'h7F, 8'h00, 1'b0, 1'b1, sa, lat, rs, rc, ro, bd, da);
    n_cmp++; if (rs !== 8'h80)  begin n_err++; $display("FAIL add3_sum got=%h exp=80", rs); end
    n_cmp++; if (rc !== 1'b0)   begin n_err++; $display("FAIL add3_cout got=%b exp=0", rc); end
    n_cmp++; if (ro !== 1'b1)   begin n_err++; $display("FAIL add3_ovf got=%b exp=1", ro); end
  endtask

  task automatic test_sub();
    logic [W-1:0] sa, rs; int lat; logic rc, ro, bd, da;
    run_op(8'h05, 8'h07, 1'b1, 1'b0, sa, lat, rs, rc, ro, bd, da);
    n_cmp++; if (rs !== 8'hFE)  begin n_err++; $display("FAIL sub1_sum got=%h exp=fe", rs); end
    n_cmp++; if (rc !== 1'b0)   begin n_err++; $display("FAIL sub1_cout got=%b exp=0", rc); end
    n_cmp++; if (ro !== 1'b0)   begin n_err++; $display("FAIL sub1_ovf got=%b exp=0", ro); end
    run_op(8'h80, 8'h01, 1'b1, 1'b0, sa, lat, rs, rc, ro, bd, da);
    n_cmp++; if (rs !== 8'h7F)  begin n_err++; $display("FAIL sub2_sum got=%h exp=7f", rs); end
    n_cmp++; if (rc !== 1'b1)   begin n_err++; $display("FAIL sub2_cout got=%b exp=1", rc); end
    n_cmp++; if (ro !== 1'b1)   begin n_err++; $display("FAIL sub2_ovf got=%b exp=1", ro); end
  endtask

  // start pulsed at E3 and across E8/E9 must not disturb 0x12+0x34.
  task automatic test_start_while_busy();
    int n_done = 0;
    @(negedge clk);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; sub = 1'b0; cin_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3 || k == 8 || k == 9) begin
        start = 1'b1; op_a = 8'hF0; op_b = 8'h0F; sub = 1'b1; cin_in = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) n_done++;
      if (k <= 9) begin
        n_cmp++;
        if (busy !== (k <= 8)) begin
          n_err++; $display("FAIL busy_ign_busy k=%0d got=%b exp=%b", k, busy, (k <= 8));
        end
      end
    end
    n_cmp++; if (n_done != 1)    begin n_err++; $display("FAIL busy_ign_done_count got=%0d exp=1", n_done); end
    n_cmp++; if (sum !== 8'h46)  begin n_err++; $display("FAIL busy_ign_sum got=%h exp=46", sum); end
    n_cmp++; if (cout !== 1'b0)  begin n_err++; $display("FAIL busy_ign_cout got=%b exp=0", cout); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] sa, rs; int lat; logic rc, ro, bd, da;
    // Leave cout=1/overflow=1 behind so the reset clearing them is visible.
    run_op(8'h80, 8'h01, 1'b1, 1'b0, sa, lat, rs, rc, ro, bd, da);
    @(negedge clk);
    start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; sub = 1'b0; cin_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL arst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL arst_done got=%b exp=0", done); end
    n_cmp++; if (sum !== 8'h00)     begin n_err++; $display("FAIL arst_sum got=%h exp=00", sum); end
    n_cmp++; if (cout !== 1'b0)     begin n_err++; $display("FAIL arst_cout got=%b exp=0", cout); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL arst_ovf got=%b exp=0", overflow); end
    @(negedge clk); rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, sa, lat, rs, rc, ro, bd, da);
    n_cmp++; if (lat != 8)      begin n_err++; $display("FAIL arst_after_latency got=%0d exp=8", lat); end
    n_cmp++; if (rs !== 8'h02)  begin n_err++; $display("FAIL arst_after_sum got=%h exp=02", rs); end
  endtask

  // start held high: accepts at E0, E10, E20 with operands swapped in after each accept.
  task automatic test_back_to_back();
    logic [W-1:0] va [3] = '{8'h10, 8'hC8, 8'h64};
    logic [W-1:0] vb [3] = '{8'h20, 8'h64, 8'hC8};
    logic         vs [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [3] = '{8'h30, 8'h2C, 8'h9C};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         eo [3] = '{1'b0, 1'b0, 1'b1};
    @(negedge clk);
    start = 1'b1; cin_in = 1'b0; op_a = va[0]; op_b = vb[0]; sub = vs[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin op_a = va[i+1]; op_b = vb[i+1]; sub = vs[i+1]; end
      for (int k = 1; k <= 9; k++) begin
        @(posedge clk); #1;
        if (i == 2 && k == 9) start = 1'b0;
        n_cmp++;
        if (done !== (k == 8)) begin
          n_err++; $display("FAIL b2b_done op=%0d k=%0d got=%b exp=%b", i, k, done, (k == 8));
        end
        if (k == 8) begin
          n_cmp++; if (sum !== es[i])      begin n_err++; $display("FAIL b2b_sum op=%0d got=%h exp=%h", i, sum, es[i]); end
          n_cmp++; if (cout !== ec[i])     begin n_err++; $display("FAIL b2b_cout op=%0d got=%b exp=%b", i, cout, ec[i]); end
          n_cmp++; if (overflow !== eo[i]) begin n_err++; $display("FAIL b2b_ovf op=%0d got=%b exp=%b", i, overflow, eo[i]); end
        end
        if (k == 9) begin
          n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap op=%0d got=%b exp=0", i, busy); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
